// File: rtl/sumador_vectorial_segmentado.sv
// sumador_vectorial_segmentado
// Multi-lane, two-stage pipelined add/subtract unit. Each of the LANES lanes
// adds or subtracts N-bit operands independently. The carry chain is split at
// the half-word boundary. Stage 1 produces the low half and its carry, and
// stage 2 produces the high half. Both sides use a valid/ready handshake.
//
// Optional feature: define SATURACION_EN to add the `sat` port. With it, a
// lane that overflows is clamped to the largest positive or negative value.
//
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   in_valid        operands valid
//   in_ready        unit accepts operands this cycle
//   A, B            operands, lane i at [i*N +: N]
//   Cin             per-lane carry-in (subtract: 1 = plain A-B)
//   op              0 = A+B+Cin, 1 = A+~B+Cin
//   sat             saturate enable (SATURACION_EN only)
//   out_valid       result valid
//   out_ready       downstream accepts result
//   S, Cout, V      per-lane sum, carry-out, signed overflow (registered)

module sumador_vectorial_segmentado #(
    parameter int N     = 32,
    parameter int LANES = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [LANES*N-1:0]   A,
    input  logic [LANES*N-1:0]   B,
    input  logic [LANES-1:0]     Cin,
    input  logic                 op,
`ifdef SATURACION_EN
    input  logic                 sat,
`endif
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [LANES*N-1:0]   S,
    output logic [LANES-1:0]     Cout,
    output logic [LANES-1:0]     V
);

    localparam int H  = N / 2;
    localparam int HP = H + 1;

    // Stage 1 registers: low-half sum and carry, plus the high halves still to be added
    logic [LANES*H-1:0]  lo_sum_q, lo_sum_d;
    logic [LANES-1:0]    lo_c_q, lo_c_d;
    logic [LANES*H-1:0]  a_hi_q, a_hi_d;
    logic [LANES*H-1:0]  b_hi_q, b_hi_d;
    logic                v1_q, v1_d;
`ifdef SATURACION_EN
    logic                sat_q, sat_d;
`endif

    // Stage 2 registers: the final result
    logic [LANES*N-1:0]  s_q, s_d;
    logic [LANES-1:0]    cout_q, cout_d;
    logic [LANES-1:0]    v_q, v_d;
    logic                v2_q, v2_d;

    logic                en1, en2;

    logic [N-1:0]        b_eff   [LANES];
    logic [H:0]          lo_full [LANES];
    logic [H:0]          hi_full [LANES];
    logic                c_msb   [LANES];
    logic [LANES-1:0]    ovf;
    logic [N-1:0]        res     [LANES];

    // A stage may advance when the stage after it is empty or is draining.
    // in_ready therefore depends combinationally on out_ready.
    always_comb begin
        en2      = ~v2_q | out_ready;
        en1      = ~v1_q | en2;
        in_ready = en1;
    end

    // Stage 1 next state. The subtract operand is inverted here, so later
    // stages only add. Data is captured only when an operation is accepted.
    always_comb begin
        lo_sum_d = lo_sum_q;
        lo_c_d   = lo_c_q;
        a_hi_d   = a_hi_q;
        b_hi_d   = b_hi_q;
        v1_d     = en1 ? in_valid : v1_q;
`ifdef SATURACION_EN
        sat_d    = (en1 & in_valid) ? sat : sat_q;
`endif
        for (int i = 0; i < LANES; i++) begin
            b_eff[i]   = op ? ~B[i*N +: N] : B[i*N +: N];
            lo_full[i] = HP'(A[i*N +: H]) + HP'(b_eff[i][H-1:0]) + HP'(Cin[i]);
            if (en1 && in_valid) begin
                lo_sum_d[i*H +: H] = lo_full[i][H-1:0];
                lo_c_d[i]          = lo_full[i][H];
                a_hi_d[i*H +: H]   = A[i*N+H +: H];
                b_hi_d[i*H +: H]   = b_eff[i][N-1:H];
            end
        end
    end

    // Stage 2 next state. The carry into the MSB is recovered as a^b^sum at
    // that bit, which avoids a separate N-1 bit adder. The output registers
    // load only when a valid stage-1 entry moves forward. As a result they keep
    // their last value while the pipeline is empty.
    always_comb begin
        s_d    = s_q;
        cout_d = cout_q;
        v_d    = v_q;
        v2_d   = en2 ? v1_q : v2_q;
        for (int i = 0; i < LANES; i++) begin
            hi_full[i] = HP'(a_hi_q[i*H +: H]) + HP'(b_hi_q[i*H +: H]) + HP'(lo_c_q[i]);
            c_msb[i]   = a_hi_q[i*H+H-1] ^ b_hi_q[i*H+H-1] ^ hi_full[i][H-1];
            ovf[i]     = c_msb[i] ^ hi_full[i][H];
            res[i]     = {hi_full[i][H-1:0], lo_sum_q[i*H +: H]};
`ifdef SATURACION_EN
            // Overflow only happens when both operands share a sign. The sign
            // of A therefore gives the direction of the clamp.
            if (sat_q && ovf[i]) begin
                res[i] = a_hi_q[i*H+H-1] ? {1'b1, {(N-1){1'b0}}} : {1'b0, {(N-1){1'b1}}};
            end
`endif
            if (en2 && v1_q) begin
                s_d[i*N +: N] = res[i];
                cout_d[i]     = hi_full[i][H];
                v_d[i]        = ovf[i];
            end
        end
    end

    // Pipeline registers. Reset discards everything in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            lo_sum_q <= '0;
            lo_c_q   <= '0;
            a_hi_q   <= '0;
            b_hi_q   <= '0;
            v1_q     <= 1'b0;
`ifdef SATURACION_EN
            sat_q    <= 1'b0;
`endif
            s_q      <= '0;
            cout_q   <= '0;
            v_q      <= '0;
            v2_q     <= 1'b0;
        end else begin
            lo_sum_q <= lo_sum_d;
            lo_c_q   <= lo_c_d;
            a_hi_q   <= a_hi_d;
            b_hi_q   <= b_hi_d;
            v1_q     <= v1_d;
`ifdef SATURACION_EN
            sat_q    <= sat_d;
`endif
            s_q      <= s_d;
            cout_q   <= cout_d;
            v_q      <= v_d;
            v2_q     <= v2_d;
        end
    end

    assign out_valid = v2_q;
    assign S         = s_q;
    assign Cout      = cout_q;
    assign V         = v_q;

endmodule

// File: tb/tb_sumador_vectorial_segmentado.sv
// Testbench for sumador_vectorial_segmentado. The reference model adds full
// lanes at N+1 bits. Expected results are queued on every accepted operation
// and compared whenever out_valid is high; the queue head is popped only on an
// output transfer. The bench also checks the saturation results when the unit
// is built with SATURACION_EN.

module tb_sumador_vectorial_segmentado;

    localparam int N     = 32;
    localparam int LANES = 4;
    localparam int W     = N * LANES;
`ifdef SATURACION_EN
    localparam bit SAT_BUILD = 1'b1;
`else
    localparam bit SAT_BUILD = 1'b0;
`endif

    logic             clk;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [W-1:0]     A;
    logic [W-1:0]     B;
    logic [LANES-1:0] Cin;
    logic             op;
    logic             sat_in;
    logic             out_valid;
    logic             out_ready;
    logic [W-1:0]     S;
    logic [LANES-1:0] Cout;
    logic [LANES-1:0] V;

    int checks   = 0;
    int failures = 0;
    int n_out    = 0;

    typedef struct {
        logic [W-1:0]     s;
        logic [LANES-1:0] c;
        logic [LANES-1:0] v;
    } res_t;

    res_t sb[$];
    res_t head;

    sumador_vectorial_segmentado #(.N(N), .LANES(LANES)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .A         (A),
        .B         (B),
        .Cin       (Cin),
        .op        (op),
`ifdef SATURACION_EN
        .sat       (sat_in),
`endif
        .out_valid (out_valid),
        .out_ready (out_ready),
        .S         (S),
        .Cout      (Cout),
        .V         (V)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Single comparison point: counts the check and reports any mismatch.
    task automatic checkOutput(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("[TB] FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Reference model: add each lane at full width and flag overflow from the operand and result signs.
    function automatic res_t model(input logic [W-1:0] a, input logic [W-1:0] b,
                                   input logic [LANES-1:0] cin, input logic o, input logic s);
        res_t r;
        logic [N-1:0] al, bl, sv;
        logic [N:0]   full;
        logic         ov;
        for (int i = 0; i < LANES; i++) begin
            al   = a[i*N +: N];
            bl   = o ? ~b[i*N +: N] : b[i*N +: N];
            full = {1'b0, al} + {1'b0, bl} + {{N{1'b0}}, cin[i]};
            sv   = full[N-1:0];
            ov   = (al[N-1] == bl[N-1]) && (sv[N-1] != al[N-1]);
            if (SAT_BUILD && s && ov) begin
                sv = al[N-1] ? {1'b1, {(N-1){1'b0}}} : {1'b0, {(N-1){1'b1}}};
            end
            r.s[i*N +: N] = sv;
            r.c[i]        = full[N];
            r.v[i]        = ov;
        end
        return r;
    endfunction

    function automatic logic [N-1:0] laneOf(input logic [W-1:0] v, input int i);
        return v[i*N +: N];
    endfunction

    // Monitor at the falling edge: handshakes seen now complete at the next
    // rising edge. A stalled output is compared against the queue head every
    // cycle, which also checks that it holds steady.
    always @(negedge clk) begin
        if (!rst) begin
            if (out_valid) begin
                if (sb.size() == 0) begin
                    checkOutput("spurious_out_valid", W'(out_valid), W'(1'b0));
                end else begin
                    checkOutput("sb_S", S, sb[0].s);
                    checkOutput("sb_Cout", W'(Cout), W'(sb[0].c));
                    checkOutput("sb_V", W'(V), W'(sb[0].v));
                    if (out_ready) begin
                        head = sb.pop_front();
                        n_out++;
                    end
                end
            end
            if (in_valid && in_ready) begin
                sb.push_back(model(A, B, Cin, op, sat_in));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Presents one operation and holds it until it is accepted (bounded wait).
    task automatic applyStimulus(input logic [W-1:0] a, input logic [W-1:0] b,
                                 input logic [LANES-1:0] cin, input logic o, input logic s);
        int  k;
        logic got;
        A = a; B = b; Cin = cin; op = o; sat_in = s;
        in_valid = 1'b1;
        k = 0;
        got = 1'b0;
        do begin
            @(negedge clk);
            got = in_ready;
            tick();
            k++;
        end while (!got && k < 100);
        in_valid = 1'b0;
        if (!got) checkOutput("accept_timeout", W'(1'b1), W'(1'b0));
    endtask

    task automatic drain();
        int k;
        k = 0;
        out_ready = 1'b1;
        while ((sb.size() != 0 || out_valid) && k < 50) begin
            tick();
            k++;
        end
        checkOutput("drain_empty", W'(sb.size()), W'(0));
    endtask

    initial begin
        int idx;
        int base;
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        op = 1'b0; sat_in = 1'b0; A = '0; B = '0; Cin = '0;
        repeat (2) tick();

        checkOutput("rst_out_valid", W'(out_valid), W'(1'b0));
        checkOutput("rst_in_ready", W'(in_ready), W'(1'b1));
        checkOutput("rst_S", S, W'(0));
        checkOutput("rst_Cout", W'(Cout), W'(0));
        checkOutput("rst_V", W'(V), W'(0));
        rst = 1'b0;

        // Add: full-width wrap, carry across the half-word split, Cin, and signed overflow.
        applyStimulus({32'h7FFFFFFF, 32'h12345678, 32'h0000FFFF, 32'hFFFFFFFF},
                      {32'h00000001, 32'h11111111, 32'h00000001, 32'h00000001},
                      4'b0100, 1'b0, 1'b0);
        checkOutput("lat_stage1_only", W'(out_valid), W'(1'b0));
        tick();
        checkOutput("lat_out_valid", W'(out_valid), W'(1'b1));
        checkOutput("add_wrap_S0", W'(laneOf(S, 0)), W'(32'h00000000));
        checkOutput("add_wrap_Cout0", W'(Cout[0]), W'(1'b1));
        checkOutput("add_wrap_V0", W'(V[0]), W'(1'b0));
        checkOutput("add_split_S1", W'(laneOf(S, 1)), W'(32'h00010000));
        checkOutput("add_split_Cout1", W'(Cout[1]), W'(1'b0));
        checkOutput("add_cin_S2", W'(laneOf(S, 2)), W'(32'h2345678A));
        checkOutput("add_ovf_S3", W'(laneOf(S, 3)), W'(32'h80000000));
        checkOutput("add_ovf_V3", W'(V[3]), W'(1'b1));

        // Subtract: borrow, no borrow, negative overflow (saturates if enabled), borrow-chain Cin=0.
        applyStimulus({32'h00000000, 32'h80000000, 32'h00000007, 32'h00000005},
                      {32'h00000000, 32'h00000001, 32'h00000005, 32'h00000007},
                      4'b0111, 1'b1, 1'b1);
        tick();
        checkOutput("sub_neg_S0", W'(laneOf(S, 0)), W'(32'hFFFFFFFE));
        checkOutput("sub_neg_Cout0", W'(Cout[0]), W'(1'b0));
        checkOutput("sub_neg_V0", W'(V[0]), W'(1'b0));
        checkOutput("sub_pos_S1", W'(laneOf(S, 1)), W'(32'h00000002));
        checkOutput("sub_pos_Cout1", W'(Cout[1]), W'(1'b1));
        checkOutput("sub_ovf_S2", W'(laneOf(S, 2)), SAT_BUILD ? W'(32'h80000000) : W'(32'h7FFFFFFF));
        checkOutput("sub_ovf_V2", W'(V[2]), W'(1'b1));
        checkOutput("sub_chain_S3", W'(laneOf(S, 3)), W'(32'hFFFFFFFF));

        // Add with sat requested: positive and negative overflow.
        applyStimulus({32'h00000003, 32'h00000004, 32'h80000000, 32'h7FFFFFFF},
                      {32'h00000004, 32'h00000005, 32'h80000000, 32'h00000001},
                      4'b0000, 1'b0, 1'b1);
        tick();
        checkOutput("sat_pos_S0", W'(laneOf(S, 0)), SAT_BUILD ? W'(32'h7FFFFFFF) : W'(32'h80000000));
        checkOutput("sat_pos_V0", W'(V[0]), W'(1'b1));
        checkOutput("sat_neg_S1", W'(laneOf(S, 1)), SAT_BUILD ? W'(32'h80000000) : W'(32'h00000000));
        checkOutput("sat_neg_Cout1", W'(Cout[1]), W'(1'b1));
        drain();

        // Random traffic with random backpressure.
        for (int c = 0; c < 60; c++) begin
            in_valid  = ($urandom_range(0, 1) == 1);
            out_ready = ($urandom_range(0, 3) != 0);
            A   = {$urandom, $urandom, $urandom, $urandom};
            B   = {$urandom, $urandom, $urandom, $urandom};
            Cin = LANES'($urandom);
            op  = ($urandom_range(0, 1) == 1);
            sat_in = ($urandom_range(0, 1) == 1);
            tick();
        end
        in_valid = 1'b0;
        drain();

        // Stream 6 back-to-back operations, holding out_ready low for cycles 3-6.
        base = n_out;
        idx  = 0;
        for (int c = 0; c < 40 && (idx < 6 || sb.size() != 0 || out_valid); c++) begin
            out_ready = !(c >= 3 && c <= 6);
            if (idx < 6) begin
                in_valid = 1'b1;
                A   = {4{32'h10000000 + 32'(idx)}};
                B   = {4{32'h0000FFFF - 32'(idx)}};
                Cin = LANES'(idx);
                op  = idx[0];
                sat_in = 1'b0;
            end else begin
                in_valid = 1'b0;
            end
            @(negedge clk);
            if (c == 3) checkOutput("bp_in_ready_full", W'(in_ready), W'(1'b0));
            if (c == 6) checkOutput("bp_in_ready_held", W'(in_ready), W'(1'b0));
            if (c == 7) checkOutput("bp_in_ready_reopen", W'(in_ready), W'(1'b1));
            if (in_valid && in_ready) idx++;
            tick();
        end
        in_valid = 1'b0;
        checkOutput("bp_result_count", W'(n_out - base), W'(6));
        drain();

        // Reset with both stages occupied.
        out_ready = 1'b0;
        in_valid  = 1'b1;
        A = {4{32'hDEADBEEF}}; B = {4{32'h01234567}}; Cin = '0; op = 1'b0;
        tick();
        A = {4{32'hCAFEF00D}};
        tick();
        in_valid = 1'b0;
        checkOutput("full_in_ready", W'(in_ready), W'(1'b0));
        checkOutput("full_out_valid", W'(out_valid), W'(1'b1));
        rst = 1'b1;
        tick();
        sb.delete();
        checkOutput("midrst_out_valid", W'(out_valid), W'(1'b0));
        checkOutput("midrst_in_ready", W'(in_ready), W'(1'b1));
        checkOutput("midrst_S", S, W'(0));
        out_ready = 1'b1;
        base = n_out;
        rst = 1'b0;
        in_valid = 1'b1;
        A = {4{32'h00000100}}; B = {4{32'h00000023}}; Cin = '0; op = 1'b0; sat_in = 1'b0;
        @(negedge clk);
        checkOutput("post_rst_in_ready", W'(in_ready), W'(1'b1));
        tick();
        in_valid = 1'b0;
        repeat (6) tick();
        checkOutput("post_rst_count", W'(n_out - base), W'(1));
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
